conv_scan_ctrl: RTL
===================

// Module: conv_scan_ctrl
// PURPOSE
//   Raster-scan sequencer for the convolution front end. Accepts one feature-map
//   pixel per handshake and drives shift_en to the external Dff-based line/window
//   buffer. Flags each accepted pixel that completes a valid KxK window and reports
//   that window's origin. Sits between the pixel source and the conv MAC array.
// PARAMETERS
//   IMG_W  32  feature-map width in pixels (>= K)
//   IMG_H  32  feature-map height in pixels (>= K)
//   K      5   square kernel size, stride fixed at 1
//   CW     $clog2(IMG_W)  column counter / win_col width (derived)
//   RW     $clog2(IMG_H)  row counter / win_row width (derived)
// PORTS
//   clk        in   1       clock, all state on posedge
//   rst_n      in   1       reset, asynchronous, active-low
//   start      in   1       begin a frame; honoured only in IDLE
//   abort      in   1       synchronous abort, any state -> IDLE
//   in_valid   in   1       pixel source has a pixel
//   in_ready   out  1       controller accepts pixel this cycle
//   shift_en   out  1       line-buffer shift; equals in_valid & in_ready
//   win_valid  out  1       registered: window at win_row/win_col is ready
//   out_ready  in   1       MAC array consumes window when win_valid & out_ready
//   win_row    out  RW      window top row (row - (K-1)), registered
//   win_col    out  CW      window left col (col - (K-1)), registered
//   win_cnt    out  16      windows consumed this frame
//   busy       out  1       high in RUN and FLUSH
//   done       out  1       one-cycle pulse, frame complete
// BEHAVIOUR
//   Reset: state=IDLE; row, col, win_row, win_col, win_cnt = 0; all 1-bit outputs 0.
//   States: IDLE, RUN, FLUSH, DONE.
//   IDLE:  in_ready=0. On start: row=col=0, win_cnt=0, go to RUN.
//          start is ignored outside IDLE.
//   RUN:   in_ready = ~win_valid | out_ready (1-deep output slot).
//          in_fire = in_valid & in_ready; shift_en = in_fire, same cycle.
//   In RUN, on in_fire:
//     - col++. When col==IMG_W-1: col wraps to 0, row++.
//     - If row>=K-1 && col>=K-1 (pre-increment values): next cycle win_valid=1,
//       win_row=row-(K-1), win_col=col-(K-1). Latency is exactly 1 cycle.
//     - If the pixel does not qualify and the slot is consumed, win_valid clears.
//     - When row==IMG_H-1 && col==IMG_W-1: go to FLUSH. Counters return to 0.
//   Slot rules:
//     - win_valid & ~out_ready: win_valid, win_row and win_col hold.
//       in_ready=0 and shift_en=0.
//     - win_cnt increments on each cycle with win_valid & out_ready.
//   FLUSH: in_ready=0. Go to DONE when ~win_valid, or when win_valid & out_ready;
//          the final window is consumed on that same edge.
//   DONE:  done=1 for this single cycle, busy=0, then IDLE. win_cnt holds until
//          the next start. At done, win_cnt = (IMG_W-K+1)*(IMG_H-K+1).
//   abort: has priority over all transitions. Next cycle state=IDLE, win_valid=0,
//          counters=0. No done pulse. Takes effect even in the cycle of start.
//   Pixels with col<K-1 or row<K-1 shift the buffer but never raise win_valid.
//   Asynchronous reset mid-frame: immediate return to reset values, no done.
// TESTING
//   1. IMG 8x8, K=3, in_valid=1, out_ready=1 throughout.
//      -> first win_valid the cycle after pixel #18 (r2,c2) fires, with win_row=0,
//         win_col=0; then 36 windows total.
//      -> done one cycle after the pixel #63 fire cycle +1; win_cnt=36.
//   2. Row wrap, IMG 8x8, K=3.
//      -> pixels #24,#25 (r3,c0/c1): shift_en=1, no win_valid.
//      -> pixel #26: win_row=1, win_col=0.
//   3. Backpressure: hold out_ready=0 for 4 cycles while win_valid=1.
//      -> in_ready=0, shift_en=0, win_row/win_col stable.
//      -> release: window consumed, win_cnt+1, in_ready=1 same cycle.
//   4. Pulse start in RUN mid-frame -> ignored, counters continue.
//      Pulse abort at pixel #40 -> IDLE next cycle, win_valid=0, no done.
//      New start -> fresh frame completes with win_cnt=36.
//   5. Deassert rst_n mid-RUN with win_valid=1 -> all outputs 0 immediately.
//      After release -> IDLE, in_ready=0 until start.
//   6. Sparse in_valid (1 of 3 cycles), out_ready random
//      -> same 36 window origins in raster order, no window lost or duplicated.

Source files
------------

// File: rtl/conv_scan_ctrl.sv
// Raster-scan sequencer for the convolution front end: counts accepted pixels,
// drives the line-buffer shift and presents each completed KxK window origin.
module conv_scan_ctrl #(
  parameter int unsigned IMG_W = 32,
  parameter int unsigned IMG_H = 32,
  parameter int unsigned K     = 5,
  parameter int unsigned CW    = $clog2(IMG_W),
  parameter int unsigned RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          shift_en,
  output logic          win_valid,
  input  logic          out_ready,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic [15:0]   win_cnt,
  output logic          busy,
  output logic          done
);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_KM1  = CW'(K - 1);
  localparam logic [RW-1:0] ROW_KM1  = RW'(K - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          in_fire;
  logic          slot_take;
  logic          col_last;
  logic          last_px;
  logic          px_qual;

  assign in_fire   = in_valid & in_ready;
  assign shift_en  = in_fire;
  assign slot_take = win_valid & out_ready;
  assign col_last  = (col_q == COL_LAST);
  assign last_px   = col_last && (row_q == ROW_LAST);
  assign px_qual   = (row_q >= ROW_KM1) && (col_q >= COL_KM1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort overrides every transition
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start) state_d = S_RUN;
        S_RUN:   if (in_fire && last_px) state_d = S_FLUSH;
        S_FLUSH: if (!win_valid || out_ready) state_d = S_DONE;
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode; the output slot is one deep, so a stalled window blocks input
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state_q)
      S_RUN: begin
        in_ready = ~win_valid | out_ready;
        busy     = 1'b1;
      end
      S_FLUSH: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Scan counters, window slot and consumed-window count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q     <= '0;
      col_q     <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      win_cnt   <= '0;
    end else if (abort) begin
      row_q     <= '0;
      col_q     <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      win_cnt   <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) begin
        row_q   <= '0;
        col_q   <= '0;
        win_cnt <= '0;
      end
    end else if (state_q == S_RUN || state_q == S_FLUSH) begin
      if (slot_take) begin
        win_cnt <= win_cnt + 16'd1;
      end
      if (in_fire && px_qual) begin
        win_valid <= 1'b1;
        win_row   <= row_q - ROW_KM1;
        win_col   <= col_q - COL_KM1;
      end else if (slot_take) begin
        win_valid <= 1'b0;
      end
      if (in_fire) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= last_px ? '0 : row_q + RW'(1);
        end else begin
          col_q <= col_q + CW'(1);
        end
      end
    end
  end

endmodule
